// File: rtl/can_pkg.sv
// Shared CAN constants and the CRC sequencer state type.
package can_pkg;

  localparam int          CAN_CRC_W        = 15;
  localparam logic [14:0] CAN_CRC_POLY     = 15'h4599;
  localparam int          CAN_MAX_CRC_BITS = 103;

  typedef enum logic [2:0] {
    IDLE,
    ACCUM,
    LOAD,
    SHIFT,
    DONE
  } crc_seq_state_e;

endpackage

// File: rtl/can_crc15_gen.sv
// Bit-serial CAN CRC-15 register: cleared on crc_init, advanced one bit per crc_en.
module can_crc15_gen
  import can_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 crc_init,
  input  logic                 crc_en,
  input  logic                 data_bit,
  output logic [CAN_CRC_W-1:0] crc_out
);

  logic [CAN_CRC_W-1:0] crc_q;
  logic                 feedback;

  assign feedback = data_bit ^ crc_q[CAN_CRC_W-1];
  assign crc_out  = crc_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      crc_q <= '0;
    end else if (crc_init) begin
      crc_q <= '0;
    end else if (crc_en) begin
      crc_q <= {crc_q[CAN_CRC_W-2:0], 1'b0} ^ (feedback ? CAN_CRC_POLY : '0);
    end
  end

endmodule

// File: rtl/can_crc_seq.sv
// Frame-level CRC sequencer: feeds covered bits to the CRC-15 generator, then
// serialises (TX) or captures and checks (RX) the 15-bit CRC field.
module can_crc_seq
  import can_pkg::*;
#(
  parameter int CRC_W    = CAN_CRC_W,
  parameter int MAX_BITS = CAN_MAX_CRC_BITS,
  parameter int CNT_W    = 7
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             mode_tx,
  input  logic             frame_start,
  input  logic             abort,
  input  logic             bit_strobe,
  input  logic             bit_in,
  input  logic             last_data_bit,
  output logic             busy,
  output logic             crc_bit_out,
  output logic             crc_bit_valid,
  output logic [CRC_W-1:0] crc_value,
  output logic             crc_field_done,
  output logic             crc_ok,
  output logic             crc_err,
  output logic             overrun
);

  crc_seq_state_e   state_q;
  logic             mode_tx_q;
  logic [CNT_W-1:0] bit_cnt_q;
  logic [3:0]       field_cnt_q;
  logic [CRC_W-1:0] tx_shreg_q;
  logic [CRC_W-1:0] rx_shreg_q;
  logic [CRC_W-1:0] rx_field_d;
  logic [CRC_W-1:0] crc_value_q;
  logic             busy_q;
  logic             valid_q;
  logic             done_q;
  logic             ok_q;
  logic             err_q;
  logic             overrun_q;

  logic             crc_init;
  logic             crc_en;
  logic [CRC_W-1:0] gen_crc;

  assign crc_init   = frame_start & ~abort;
  assign crc_en     = (state_q == ACCUM) & bit_strobe;
  assign rx_field_d = {rx_shreg_q[CRC_W-2:0], bit_in};

  can_crc15_gen u_gen (
    .clk      (clk),
    .rst_n    (rst_n),
    .crc_init (crc_init),
    .crc_en   (crc_en),
    .data_bit (bit_in),
    .crc_out  (gen_crc)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      mode_tx_q   <= 1'b0;
      bit_cnt_q   <= '0;
      field_cnt_q <= '0;
      tx_shreg_q  <= '0;
      rx_shreg_q  <= '0;
      crc_value_q <= '0;
      busy_q      <= 1'b0;
      valid_q     <= 1'b0;
      done_q      <= 1'b0;
      ok_q        <= 1'b0;
      err_q       <= 1'b0;
      overrun_q   <= 1'b0;
    end else begin
      done_q    <= 1'b0;
      ok_q      <= 1'b0;
      err_q     <= 1'b0;
      overrun_q <= 1'b0;
      if (abort) begin
        state_q <= IDLE;
        busy_q  <= 1'b0;
        valid_q <= 1'b0;
      end else if (frame_start) begin
        state_q     <= ACCUM;
        mode_tx_q   <= mode_tx;
        bit_cnt_q   <= '0;
        field_cnt_q <= '0;
        busy_q      <= 1'b1;
        valid_q     <= 1'b0;
      end else begin
        case (state_q)
          ACCUM: begin
            if (bit_strobe) begin
              if (last_data_bit) begin
                state_q   <= LOAD;
                bit_cnt_q <= bit_cnt_q + 1'b1;
              end else if (bit_cnt_q == CNT_W'(MAX_BITS)) begin
                state_q   <= IDLE;
                busy_q    <= 1'b0;
                overrun_q <= 1'b1;
              end else begin
                bit_cnt_q <= bit_cnt_q + 1'b1;
              end
            end
          end
          LOAD: begin
            // Generator output settled on the previous edge; snapshot it.
            crc_value_q <= gen_crc;
            tx_shreg_q  <= gen_crc;
            rx_shreg_q  <= '0;
            field_cnt_q <= '0;
            valid_q     <= mode_tx_q;
            state_q     <= SHIFT;
          end
          SHIFT: begin
            if (bit_strobe) begin
              tx_shreg_q  <= {tx_shreg_q[CRC_W-2:0], 1'b0};
              rx_shreg_q  <= rx_field_d;
              field_cnt_q <= field_cnt_q + 1'b1;
              if (field_cnt_q == 4'(CRC_W - 1)) begin
                state_q <= DONE;
                valid_q <= 1'b0;
                done_q  <= 1'b1;
                // Compare includes the bit arriving with this final strobe.
                if (!mode_tx_q) begin
                  ok_q  <= (rx_field_d == crc_value_q);
                  err_q <= (rx_field_d != crc_value_q);
                end
              end
            end
          end
          DONE: begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
          end
          default: begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
            valid_q <= 1'b0;
          end
        endcase
      end
    end
  end

  assign busy           = busy_q;
  assign crc_bit_out    = tx_shreg_q[CRC_W-1];
  assign crc_bit_valid  = valid_q;
  assign crc_value      = crc_value_q;
  assign crc_field_done = done_q;
  assign crc_ok         = ok_q;
  assign crc_err        = err_q;
  assign overrun        = overrun_q;

endmodule

// File: tb/tb_can_crc_seq.sv
// Randomised bench for can_crc_seq: CRC expectations come from polynomial long division.
module tb_can_crc_seq;

  localparam int MAXB = 103;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        mode_tx = 1'b0, frame_start = 1'b0, abort = 1'b0;
  logic        bit_strobe = 1'b0, bit_in = 1'b0, last_data_bit = 1'b0;
  logic        busy, crc_bit_out, crc_bit_valid, crc_field_done, crc_ok, crc_err, overrun;
  logic [14:0] crc_value;

  int n_cmp = 0;
  int n_bad = 0;

  // Expected outputs after the next rising edge (n_*) and the snapshot in use (e_*).
  logic        n_busy = 0, n_valid = 0, n_bit = 0, n_done = 0, n_ok = 0, n_err = 0, n_ovr = 0;
  logic        n_chkbit = 1, n_chkcrc = 1;
  logic [14:0] n_crc = '0;
  logic        e_busy, e_valid, e_bit, e_done, e_ok, e_err, e_ovr, e_chkbit, e_chkcrc;
  logic [14:0] e_crc;

  can_crc_seq dut (
    .clk(clk), .rst_n(rst_n), .mode_tx(mode_tx), .frame_start(frame_start),
    .abort(abort), .bit_strobe(bit_strobe), .bit_in(bit_in),
    .last_data_bit(last_data_bit), .busy(busy), .crc_bit_out(crc_bit_out),
    .crc_bit_valid(crc_bit_valid), .crc_value(crc_value),
    .crc_field_done(crc_field_done), .crc_ok(crc_ok), .crc_err(crc_err),
    .overrun(overrun)
  );

  always #5 clk = ~clk;

  task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
    end
  endtask

  // CRC as remainder of msg * x^15 divided by x^15 + 0x4599.
  function automatic logic [14:0] crc_model(input bit d[$]);
    bit          b[$];
    logic [15:0] g;
    logic [14:0] r;
    int          n;
    g = 16'hC599;
    b = d;
    n = d.size();
    for (int j = 0; j < 15; j++) b.push_back(1'b0);
    for (int i = 0; i < n; i++)
      if (b[i]) for (int j = 0; j < 16; j++) b[i+j] = b[i+j] ^ g[15-j];
    r = '0;
    for (int j = 0; j < 15; j++) r = {r[13:0], b[n+j]};
    return r;
  endfunction

  always @(posedge clk) begin
    e_busy = n_busy; e_valid = n_valid; e_bit = n_bit; e_done = n_done;
    e_ok = n_ok; e_err = n_err; e_ovr = n_ovr; e_chkbit = n_chkbit;
    e_chkcrc = n_chkcrc; e_crc = n_crc;
    #2;
    cmp("busy", 32'(busy), 32'(e_busy));
    cmp("crc_bit_valid", 32'(crc_bit_valid), 32'(e_valid));
    cmp("crc_field_done", 32'(crc_field_done), 32'(e_done));
    cmp("crc_ok", 32'(crc_ok), 32'(e_ok));
    cmp("crc_err", 32'(crc_err), 32'(e_err));
    cmp("overrun", 32'(overrun), 32'(e_ovr));
    if (e_chkbit) cmp("crc_bit_out", 32'(crc_bit_out), 32'(e_bit));
    if (e_chkcrc) cmp("crc_value", 32'(crc_value), 32'(e_crc));
  end

  task automatic drive(input bit fs, input bit ab, input bit st, input bit bi, input bit ld, input bit md);
    frame_start = fs; abort = ab; bit_strobe = st; bit_in = bi; last_data_bit = ld;
    mode_tx = fs ? md : 1'($urandom);
    n_done = 0; n_ok = 0; n_err = 0; n_ovr = 0;
  endtask

  task automatic go();
    @(negedge clk);
  endtask

  // Gap cycle: no strobe; random last_data_bit must be ignored.
  task automatic gap();
    drive(0, 0, 0, 1'($urandom), 1'($urandom), 0);
  endtask

  task automatic do_start(input bit tx);
    drive(1, 0, 0, 1'($urandom), 0, tx);
    n_busy = 1; n_valid = 0; n_chkbit = 0;
    go();
  endtask

  // intr_kind: 0 none, 1 abort, 2 abort+frame_start, 3 restart (frame_start, new mode)
  task automatic do_body(input bit tx, input bit d[$], input bit with_last, input logic [14:0] field,
                         input int intr_at, input int intr_kind, input bit new_tx);
    logic [14:0] c;
    bit          lst;
    c = crc_model(d);
    for (int i = 0; i < d.size(); i++) begin
      lst = with_last && (i == d.size() - 1);
      drive(0, 0, 1, d[i], lst, 0);
      if (!lst && i == MAXB) begin
        n_ovr = 1; n_busy = 0;
        go();
        gap(); go();
        return;
      end
      go();
      gap();
      if (lst) begin
        n_valid = tx; n_chkbit = tx; n_bit = c[14]; n_chkcrc = 1; n_crc = c;
      end
      go();
    end
    for (int k = 0; k < 15; k++) begin
      if (k == intr_at && intr_kind != 0) begin
        drive(intr_kind >= 2, intr_kind <= 2, 1'($urandom), 1'($urandom), 1'($urandom), new_tx);
        n_busy = (intr_kind == 3); n_valid = 0; n_chkbit = 0;
        go();
        return;
      end
      drive(0, 0, 1, tx ? 1'($urandom) : field[14-k], 1'($urandom), 0);
      if (k < 14) begin
        n_bit = c[13-k];
      end else begin
        n_valid = 0; n_chkbit = 0; n_done = 1;
        n_ok = !tx && (field == c);
        n_err = !tx && (field != c);
      end
      go();
      gap();
      if (k == 14) n_busy = 0;
      go();
    end
  endtask

  initial begin
    bit          q[$];
    bit          tx, tx2;
    int          n, kind, at;
    logic [14:0] f, c;

    // Reset: all outputs zero while rst_n is low.
    repeat (3) go();
    rst_n = 1'b1;
    n_chkbit = 0;
    repeat (2) begin gap(); go(); end

    // TX, one covered bit = 1.
    q = {1'b1};
    cmp("pin_model_1bit", 32'(crc_model(q)), 32'h4599);
    do_start(1); do_body(1, q, 1, 15'h0, -1, 0, 0);
    cmp("t1_crc_value", 32'(crc_value), 32'h4599);

    // TX, 20 zero bits.
    q = {};
    repeat (20) q.push_back(1'b0);
    cmp("pin_model_20zero", 32'(crc_model(q)), 32'h0);
    do_start(1); do_body(1, q, 1, 15'h0, -1, 0, 0);
    cmp("t2_crc_value", 32'(crc_value), 32'h0);

    // RX good and bad field after one covered bit = 1.
    q = {1'b1};
    do_start(0); do_body(0, q, 1, 15'h4599, -1, 0, 0);
    do_start(0); do_body(0, q, 1, 15'h4598, -1, 0, 0);

    // Abort after 7 field strobes; abort together with frame_start.
    q = {1'b1, 1'b0, 1'b1};
    do_start(0); do_body(0, q, 1, 15'h1234, 7, 1, 0);
    gap(); go();
    do_start(1); do_body(1, q, 1, 15'h0, 3, 2, 0);
    gap(); go();

    // frame_start in SHIFT restarts; the next frame is checked independently.
    q = {1'b0, 1'b1, 1'b1, 1'b0};
    do_start(1); do_body(1, q, 1, 15'h0, 5, 3, 0);
    q = {1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
    do_body(0, q, 1, crc_model(q), -1, 0, 0);

    // Overrun after 104 strobes without last; exactly 103 with last is legal.
    q = {};
    repeat (104) q.push_back(1'($urandom));
    do_start(1); do_body(1, q, 0, 15'h0, -1, 0, 0);
    q = {};
    repeat (103) q.push_back(1'($urandom));
    do_start(1); do_body(1, q, 1, 15'h0, -1, 0, 0);

    // Randomised frames.
    for (int r = 0; r < 30; r++) begin
      n = $urandom_range(1, MAXB);
      q = {};
      repeat (n) q.push_back(1'($urandom));
      tx = 1'($urandom);
      c = crc_model(q);
      f = ($urandom_range(0, 1) == 0) ? c : (c ^ 15'(1 << $urandom_range(0, 14)));
      kind = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 3) : 0;
      at = $urandom_range(0, 14);
      tx2 = 1'($urandom);
      do_start(tx);
      do_body(tx, q, 1, f, at, kind, tx2);
      if (kind == 3) begin
        q = {};
        repeat ($urandom_range(1, 40)) q.push_back(1'($urandom));
        c = crc_model(q);
        do_body(tx2, q, 1, ($urandom_range(0, 1) == 0) ? c : ~c, -1, 0, 0);
      end
      repeat ($urandom_range(0, 3)) begin
        drive(0, 0, 1'($urandom), 1'($urandom), 1'($urandom), 0);
        go();
      end
    end

    gap(); go();
    gap(); go();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
